cdb_arbiter: RTL and testbench

CDB_ARBITER -- requirements
Module: cdb_arbiter

---
 rtl/cdb_arbiter.sv | 110 +++++++++++
 tb/tb_cdb_arbiter.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/cdb_arbiter.sv
`default_nettype none
// ---- cdb_arbiter : per-source result FIFOs feeding one common-data-bus broadcast per cycle ----
// ---- Macro CDB_RR_EN selects round-robin arbitration (default: fixed priority). Rev 1.0 ------
module cdb_arbiter #(
   parameter int NUM_SRC    = 3,
   parameter int TAG_W      = 5,
   parameter int DATA_W     = 32,
   parameter int FIFO_DEPTH = 2
) (
   input  logic                        clk,
   input  logic                        rst_n,
   input  logic [NUM_SRC-1:0]          src_valid,
   output logic [NUM_SRC-1:0]          src_ready,
   input  logic [NUM_SRC*TAG_W-1:0]    src_tag,
   input  logic [NUM_SRC*DATA_W-1:0]   src_value,
   input  logic                        flush,
   output logic                        cdb_valid,
   output logic [TAG_W-1:0]            cdb_tag,
   output logic [DATA_W-1:0]           cdb_value,
   output logic [$clog2(NUM_SRC)-1:0]  cdb_src,
   output logic                        cdb_conflict
);
   localparam int SRC_W = $clog2(NUM_SRC);
   localparam int PTR_W = $clog2(FIFO_DEPTH);
   localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
   localparam int ENT_W = TAG_W + DATA_W;

   logic [NUM_SRC-1:0] w_nonempty;
   logic [NUM_SRC-1:0] w_push;
   logic [ENT_W-1:0]   w_head [NUM_SRC];
   logic               w_grant_vld;
   logic [SRC_W-1:0]   w_grant_idx;

   for (genvar i = 0; i < NUM_SRC; i++) begin : g_src
      logic [ENT_W-1:0] r_mem [FIFO_DEPTH];
      logic [PTR_W-1:0] r_wr_ptr;
      logic [PTR_W-1:0] r_rd_ptr;
      logic [CNT_W-1:0] r_count;
      logic             w_pop;

      assign src_ready[i]  = (r_count != CNT_W'(FIFO_DEPTH));
      assign w_push[i]     = src_valid[i] & src_ready[i];
      assign w_pop         = w_grant_vld && (w_grant_idx == SRC_W'(i));
      assign w_nonempty[i] = (r_count != '0);
      assign w_head[i]     = r_mem[r_rd_ptr];

      always_ff @(posedge clk) begin
         if (!rst_n || flush) begin
            r_count  <= '0;
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
         end else begin
            if (w_push[i]) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            if (w_pop)     r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            if (w_push[i] && !w_pop)
               r_count <= r_count + CNT_W'(1);
            else if (!w_push[i] && w_pop)
               r_count <= r_count - CNT_W'(1);
         end
      end

      // Storage is not reset; a write whose pointer never advances is harmless.
      always_ff @(posedge clk) begin
         if (w_push[i])
            r_mem[r_wr_ptr] <= {src_tag[i*TAG_W +: TAG_W], src_value[i*DATA_W +: DATA_W]};
      end
   end

`ifdef CDB_RR_EN
   // r_rr_ptr holds the next search start, i.e. last_grant+1 mod NUM_SRC; 0 after reset.
   logic [SRC_W-1:0] r_rr_ptr;
   int               w_scan;

   always_comb begin
      w_grant_vld = 1'b0;
      w_grant_idx = '0;
      w_scan      = 0;
      for (int k = 0; k < NUM_SRC; k++) begin
         w_scan = int'(r_rr_ptr) + k;
         if (w_scan >= NUM_SRC) w_scan = w_scan - NUM_SRC;
         if (!w_grant_vld && w_nonempty[SRC_W'(w_scan)]) begin
            w_grant_vld = 1'b1;
            w_grant_idx = SRC_W'(w_scan);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n)
         r_rr_ptr <= '0;
      else if (!flush && w_grant_vld)
         r_rr_ptr <= (w_grant_idx == SRC_W'(NUM_SRC - 1)) ? '0 : w_grant_idx + SRC_W'(1);
   end
`else
   always_comb begin
      w_grant_vld = |w_nonempty;
      w_grant_idx = '0;
      for (int k = NUM_SRC - 1; k >= 0; k--) begin
         if (w_nonempty[SRC_W'(k)]) w_grant_idx = SRC_W'(k);
      end
   end
`endif

   assign cdb_valid    = w_grant_vld;
   assign cdb_src      = w_grant_idx;
   assign {cdb_tag, cdb_value} = w_grant_vld ? w_head[w_grant_idx] : '0;
   assign cdb_conflict = |(w_nonempty & (w_nonempty - NUM_SRC'(1)));

endmodule
`default_nettype wire

// File: tb/tb_cdb_arbiter.sv
`default_nettype none
// tb_cdb_arbiter : directed table plus hand-written sequences for the CDB arbiter.
module tb_cdb_arbiter;
   logic        clk = 1'b0;
   logic        rst_n;
   logic [2:0]  src_valid;
   logic [2:0]  src_ready;
   logic [14:0] src_tag;
   logic [95:0] src_value;
   logic        flush;
   logic        cdb_valid;
   logic [4:0]  cdb_tag;
   logic [31:0] cdb_value;
   logic [1:0]  cdb_src;
   logic        cdb_conflict;

   int checks = 0;
   int errors = 0;

   cdb_arbiter #(.NUM_SRC(3), .TAG_W(5), .DATA_W(32), .FIFO_DEPTH(2)) dut (
      .clk(clk), .rst_n(rst_n), .src_valid(src_valid), .src_ready(src_ready),
      .src_tag(src_tag), .src_value(src_value), .flush(flush),
      .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_value(cdb_value),
      .cdb_src(cdb_src), .cdb_conflict(cdb_conflict)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic        rst_n, flush;
      logic [2:0]  vld;
      logic [4:0]  t0, t1, t2;
      logic [31:0] v0;
      logic        ev;
      logic [4:0]  etag;
      logic [31:0] evalue;
      logic [1:0]  esrc;
      logic        econf;
      logic [2:0]  erdy;
   } vec_t;

   vec_t tbl[$];

   // Sources 1 and 2 carry a value derived from their tag and index.
   function automatic logic [31:0] sval(input int i, input logic [4:0] t);
      return {16'hC0DE, 8'(i), 3'b000, t};
   endfunction

   task automatic add(input logic r, input logic f, input logic [2:0] vl,
                      input logic [4:0] a0, input logic [31:0] d0,
                      input logic [4:0] a1, input logic [4:0] a2,
                      input logic ev, input logic [4:0] et, input logic [31:0] evl,
                      input logic [1:0] es, input logic ec, input logic [2:0] er);
      vec_t v;
      v.rst_n = r; v.flush = f; v.vld = vl; v.t0 = a0; v.v0 = d0; v.t1 = a1; v.t2 = a2;
      v.ev = ev; v.etag = et; v.evalue = evl; v.esrc = es; v.econf = ec; v.erdy = er;
      tbl.push_back(v);
   endtask

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic drive(input logic r, input logic f, input logic [2:0] vl,
                        input logic [4:0] a0, input logic [31:0] d0,
                        input logic [4:0] a1, input logic [4:0] a2);
      rst_n     = r;
      flush     = f;
      src_valid = vl;
      src_tag   = {a2, a1, a0};
      src_value = {sval(2, a2), sval(1, a1), d0};
   endtask

   task automatic check_out(input string nm, input logic ev, input logic [4:0] et,
                            input logic [31:0] evl, input logic [1:0] es,
                            input logic ec, input logic [2:0] er);
      chk({nm, ".valid"},    64'(cdb_valid),    64'(ev));
      chk({nm, ".tag"},      64'(cdb_tag),      64'(et));
      chk({nm, ".value"},    64'(cdb_value),    64'(evl));
      chk({nm, ".src"},      64'(cdb_src),      64'(es));
      chk({nm, ".conflict"}, 64'(cdb_conflict), 64'(ec));
      chk({nm, ".ready"},    64'(src_ready),    64'(er));
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      logic [1:0] exp_src;

      drive(1'b0, 1'b0, 3'b000, 5'd0, 32'd0, 5'd0, 5'd0);
      repeat (2) @(posedge clk);
      #1;

      // Outputs checked reflect state before the edge that consumes the row's inputs.
      add(1,0,3'b000, 0,32'h0,          0, 0,  0, 0, 32'h0,          0,0,3'b111);
      add(1,0,3'b001, 3,32'hDEAD_BEEF,  0, 0,  0, 0, 32'h0,          0,0,3'b111);
      add(1,0,3'b000, 0,32'h0,          0, 0,  1, 3, 32'hDEAD_BEEF,  0,0,3'b111);
      add(1,0,3'b000, 0,32'h0,          0, 0,  0, 0, 32'h0,          0,0,3'b111);
      add(0,0,3'b000, 0,32'h0,          0, 0,  0, 0, 32'h0,          0,0,3'b111);
      add(1,0,3'b111,10,32'hA000_000A, 11,12,  0, 0, 32'h0,          0,0,3'b111);
      add(1,0,3'b000, 0,32'h0,          0, 0,  1,10, 32'hA000_000A,  0,1,3'b111);
      add(1,0,3'b000, 0,32'h0,          0, 0,  1,11, 32'hC0DE_010B,  1,1,3'b111);
      add(1,0,3'b000, 0,32'h0,          0, 0,  1,12, 32'hC0DE_020C,  2,0,3'b111);
      add(1,0,3'b000, 0,32'h0,          0, 0,  0, 0, 32'h0,          0,0,3'b111);
`ifndef CDB_RR_EN
      // src0 busy every cycle starves src1, which fills and back-pressures.
      add(1,0,3'b011,16,32'h0000_1010, 20, 0,  0, 0, 32'h0,          0,0,3'b111);
      add(1,0,3'b011,17,32'h0000_1011, 21, 0,  1,16, 32'h0000_1010,  0,1,3'b111);
      add(1,0,3'b011,18,32'h0000_1012, 22, 0,  1,17, 32'h0000_1011,  0,1,3'b101);
      add(1,0,3'b010, 0,32'h0,         22, 0,  1,18, 32'h0000_1012,  0,1,3'b101);
      add(1,0,3'b010, 0,32'h0,         22, 0,  1,20, 32'hC0DE_0114,  1,0,3'b101);
      add(1,0,3'b010, 0,32'h0,         22, 0,  1,21, 32'hC0DE_0115,  1,0,3'b111);
      add(1,0,3'b000, 0,32'h0,          0, 0,  1,22, 32'hC0DE_0116,  1,0,3'b111);
      add(1,0,3'b000, 0,32'h0,          0, 0,  0, 0, 32'h0,          0,0,3'b111);
`endif
      add(1,0,3'b011, 1,32'h0000_0001,  2, 0,  0, 0, 32'h0,          0,0,3'b111);
      add(1,0,3'b011, 3,32'h0000_0003,  4, 0,  1, 1, 32'h0000_0001,  0,1,3'b111);
`ifdef CDB_RR_EN
      add(1,1,3'b101, 5,32'h0000_0005,  0, 6,  1, 2, 32'hC0DE_0102,  1,1,3'b101);
`else
      add(1,1,3'b101, 5,32'h0000_0005,  0, 6,  1, 3, 32'h0000_0003,  0,1,3'b101);
`endif
      add(1,0,3'b000, 0,32'h0,          0, 0,  0, 0, 32'h0,          0,0,3'b111);
      add(1,0,3'b000, 0,32'h0,          0, 0,  0, 0, 32'h0,          0,0,3'b111);

      foreach (tbl[n]) begin
         drive(tbl[n].rst_n, tbl[n].flush, tbl[n].vld, tbl[n].t0, tbl[n].v0, tbl[n].t1, tbl[n].t2);
         #1;
         check_out($sformatf("vec%0d", n), tbl[n].ev, tbl[n].etag, tbl[n].evalue,
                   tbl[n].esrc, tbl[n].econf, tbl[n].erdy);
         tick();
      end

      // Reset mid-stream with entries buffered and pushes arriving during reset.
      drive(1'b1, 1'b0, 3'b111, 5'd7, 32'h0000_0007, 5'd8, 5'd9);
      tick();
      drive(1'b1, 1'b0, 3'b000, 5'd0, 32'h0, 5'd0, 5'd0);
      #1;
      chk("midrst.pre_valid", 64'(cdb_valid), 64'd1);
      chk("midrst.pre_conflict", 64'(cdb_conflict), 64'd1);
      tick();
      drive(1'b0, 1'b0, 3'b111, 5'd13, 32'h0000_000D, 5'd14, 5'd15);
      #1;
      chk("midrst.in_rst_valid", 64'(cdb_valid), 64'd1);
      tick();
      drive(1'b1, 1'b0, 3'b000, 5'd0, 32'h0, 5'd0, 5'd0);
      #1;
      check_out("midrst.after", 0, 0, 32'h0, 0, 0, 3'b111);
      tick();
      check_out("midrst.after2", 0, 0, 32'h0, 0, 0, 3'b111);

      // src0 and src2 valid every cycle: alternating under round-robin, src0 only otherwise.
      for (int c = 0; c < 6; c++) begin
         drive(1'b1, 1'b0, 3'b101, 5'(16 + c), 32'h0000_2000 + 32'(c), 5'd0, 5'(c));
         #1;
         if (c == 0) begin
            chk("fair.c0_valid", 64'(cdb_valid), 64'd0);
         end else begin
`ifdef CDB_RR_EN
            exp_src = (c % 2 == 1) ? 2'd0 : 2'd2;
`else
            exp_src = 2'd0;
`endif
            chk($sformatf("fair.c%0d_valid", c), 64'(cdb_valid), 64'd1);
            chk($sformatf("fair.c%0d_src", c), 64'(cdb_src), 64'(exp_src));
         end
         tick();
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
`default_nettype wire
